// File: rtl/rs_latch_driver.sv
// Drives the S/R inputs of an asynchronous NOR set/reset latch with a timed,
// non-overlapping pulse, then confirms the result through a synchronized readback.
module rs_latch_driver #(
    parameter int PULSE_W = 3,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST_L,
    input  logic REQ_VALID,
    input  logic REQ_VAL,
    output logic REQ_READY,
    output logic S,
    output logic R,
    input  logic Q_IN,
    output logic Q_SYNC,
    output logic DONE,
    output logic ERR
);

    localparam int CNT_MAX_PG = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_MAX    = (CNT_MAX_PG > TIMEOUT) ? CNT_MAX_PG : TIMEOUT;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    // INIT_PULSE spends its first cycle raising R, so it counts one further.
    localparam logic [CNT_W-1:0] INIT_PULSE_LAST = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] PULSE_LAST      = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST        = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST    = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_INIT_PULSE = 3'd0;
    localparam logic [2:0] ST_INIT_GAP   = 3'd1;
    localparam logic [2:0] ST_INIT_CHECK = 3'd2;
    localparam logic [2:0] ST_IDLE       = 3'd3;
    localparam logic [2:0] ST_PULSE      = 3'd4;
    localparam logic [2:0] ST_GAP        = 3'd5;
    localparam logic [2:0] ST_CHECK      = 3'd6;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             target;
    logic             q_meta;

    // NOTE: every register, including both synchronizer flops, is reset so a
    // stale readback from before reset can never be mistaken for a match.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            state     <= ST_INIT_PULSE;
            cnt       <= '0;
            target    <= 1'b0;
            S         <= 1'b0;
            R         <= 1'b0;
            REQ_READY <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            q_meta    <= 1'b0;
            Q_SYNC    <= 1'b0;
        end else begin
            q_meta <= Q_IN;
            Q_SYNC <= q_meta;
            DONE   <= 1'b0;
            ERR    <= 1'b0;

            case (state)
                ST_INIT_PULSE: begin
                    if (cnt == INIT_PULSE_LAST) begin
                        R     <= 1'b0;
                        cnt   <= '0;
                        state <= ST_INIT_GAP;
                    end else begin
                        R   <= 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_INIT_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        target <= 1'b0;
                        state  <= ST_INIT_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_INIT_CHECK, ST_CHECK: begin
                    if (Q_SYNC == target) begin
                        state     <= ST_IDLE;
                        REQ_READY <= 1'b1;
                        DONE      <= (state == ST_CHECK);
                    end else if (cnt == TIMEOUT_LAST) begin
                        state     <= ST_IDLE;
                        REQ_READY <= 1'b1;
                        ERR       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        target    <= REQ_VAL;
                        S         <= REQ_VAL;
                        R         <= ~REQ_VAL;
                        REQ_READY <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_PULSE;
                    end
                end

                ST_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    S         <= 1'b0;
                    R         <= 1'b0;
                    REQ_READY <= 1'b0;
                    cnt       <= '0;
                    state     <= ST_INIT_PULSE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_latch_driver.sv
// Bench for rs_latch_driver: behavioural NOR latch, directed requests, and a
// scoreboard monitor that matches every DONE/ERR against its expected cycle.
module tb_rs_latch_driver;

    localparam int PW = 3;
    localparam int GW = 2;
    localparam int TO = 16;

    logic CLK = 1'b0;
    logic RST_L, REQ_VALID, REQ_VAL;
    logic REQ_READY, S, R, Q_IN, Q_SYNC, DONE, ERR;

    logic q_latch = 1'b1;
    bit   stuck   = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    typedef struct {
        bit is_err;
        int at_cyc;
    } exp_t;

    exp_t sb[$];

    rs_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .RST_L     (RST_L),
        .REQ_VALID (REQ_VALID),
        .REQ_VAL   (REQ_VAL),
        .REQ_READY (REQ_READY),
        .S         (S),
        .R         (R),
        .Q_IN      (Q_IN),
        .Q_SYNC    (Q_SYNC),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Cross-coupled NOR latch reduced to its settled behaviour: 20 ns loop delay.
    always @(S or R) begin
        if (S === 1'b1)
            q_latch <= #20 1'b1;
        else if (R === 1'b1)
            q_latch <= #20 1'b0;
    end

    assign Q_IN = stuck ? 1'b0 : q_latch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: invariants every cycle, and every DONE/ERR is matched to the scoreboard.
    always @(negedge CLK) begin
        if (RST_L === 1'b1) begin
            check("s_and_r_overlap", 32'(S & R), 0);
            check("done_and_err_overlap", 32'(DONE & ERR), 0);
        end
        if (DONE === 1'b1 || ERR === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done_err", {30'd0, DONE, ERR}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_kind_err", 32'(ERR), 32'(e.is_err));
                check("resp_kind_done", 32'(DONE), 32'(!e.is_err));
                check("resp_cycle", cyc, e.at_cyc);
            end
        end
    end

    // INIT sequence after RST_L is raised at a falling edge.
    task automatic check_init();
        for (int k = 1; k <= PW + GW + 2; k++) begin
            @(negedge CLK);
            check($sformatf("init_r_c%0d", k), 32'(R), 32'(k <= PW));
            check($sformatf("init_s_c%0d", k), 32'(S), 0);
            check($sformatf("init_ready_c%0d", k), 32'(REQ_READY), 32'(k == PW + GW + 2));
        end
    endtask

    // One request: handshake, then pulse/gap/check-start shape through cycle PW+GW+1.
    task automatic run_req(input bit val, input bit err_exp, input bit toggle);
        int   h;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (REQ_READY === 1'b1) break;
        end
        check("ready_wait", 32'(REQ_READY), 1);
        REQ_VALID = 1'b1;
        REQ_VAL   = val;
        @(posedge CLK);
        #1;
        h = cyc;
        e.is_err = err_exp;
        e.at_cyc = err_exp ? h + PW + GW + TO : h + PW + GW + 1;
        sb.push_back(e);
        if (!toggle) REQ_VALID = 1'b0;
        for (int k = 1; k <= PW + GW + 1; k++) begin
            @(negedge CLK);
            check($sformatf("req_s_c%0d", k), 32'(S), (k <= PW) ? 32'(val) : 0);
            check($sformatf("req_r_c%0d", k), 32'(R), (k <= PW) ? 32'(!val) : 0);
            check($sformatf("req_ready_c%0d", k), 32'(REQ_READY), 0);
            if (toggle) REQ_VAL = ~REQ_VAL;
        end
        if (toggle) begin
            @(posedge CLK);
            #1;
            REQ_VALID = 1'b0;
        end
    endtask

    task automatic check_idle(input bit qv);
        @(negedge CLK);
        check("idle_ready", 32'(REQ_READY), 1);
        check("idle_q_sync", 32'(Q_SYNC), 32'(qv));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST_L     = 1'b0;
        REQ_VALID = 1'b0;
        REQ_VAL   = 1'b0;

        // Reset state, latch starting at Q = 1.
        repeat (3) @(negedge CLK);
        check("rst_s", 32'(S), 0);
        check("rst_r", 32'(R), 0);
        check("rst_ready", 32'(REQ_READY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_err", 32'(ERR), 0);
        check("rst_q_sync", 32'(Q_SYNC), 0);
        RST_L = 1'b1;
        check_init();

        // Single set request.
        run_req(1'b1, 1'b0, 1'b0);
        check_idle(1'b1);

        // Back-to-back: set, then reset handshaken in the DONE cycle.
        run_req(1'b1, 1'b0, 1'b0);
        run_req(1'b0, 1'b0, 1'b0);
        check_idle(1'b0);

        // Readback stuck at 0: set request must time out.
        stuck = 1'b1;
        run_req(1'b1, 1'b1, 1'b0);
        repeat (TO - 1) @(negedge CLK);
        check_idle(1'b0);
        stuck = 1'b0;

        // Reset during the second cycle of a set pulse.
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (REQ_READY === 1'b1) break;
        end
        check("abort_ready_wait", 32'(REQ_READY), 1);
        REQ_VALID = 1'b1;
        REQ_VAL   = 1'b1;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("abort_s_c1", 32'(S), 1);
        @(negedge CLK);
        check("abort_s_c2", 32'(S), 1);
        RST_L = 1'b0;
        @(negedge CLK);
        check("abort_s_dropped", 32'(S), 0);
        check("abort_r_low", 32'(R), 0);
        check("abort_ready_low", 32'(REQ_READY), 0);
        @(negedge CLK);
        RST_L = 1'b1;
        check_init();

        // Inputs toggling outside IDLE must not disturb the captured value.
        run_req(1'b1, 1'b0, 1'b1);
        check_idle(1'b1);

        repeat (10) @(negedge CLK);
        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_latch_driver.md
# rs_latch_driver

Synchronous controller that drives the S/R inputs of an asynchronous cross-coupled NOR set/reset latch and confirms the result by reading the latch output back. Accepts a requested latch value over a valid/ready handshake. Issues a single, width-controlled, never-overlapping S or R pulse followed by a quiet gap. Verifies the latch's Q through a two-flop synchronizer and reports DONE or ERR. Sits between clocked control logic and a latch placed in the Sequential library.

## Interface
Parameters:
- PULSE_W, 3: cycles S or R is held high per write; legal ≥ 1.
- GAP_W, 2: cycles both S and R are held low after a pulse, before checking; legal ≥ 1.
- TIMEOUT, 16: maximum CHECK cycles waiting for readback match; legal ≥ 1.

Ports:
- CLK, input, 1: single clock, rising edge.
- RST_L, input, 1: reset. Synchronous and active-low, sampled on the CLK rising edge.
- REQ_VALID, input, 1: a write request is present.
- REQ_VAL, input, 1: requested latch value (1 = set, 0 = reset).
- REQ_READY, output, 1: the block can accept a request.
- S, output, 1: registered set drive to the latch.
- R, output, 1: registered reset drive to the latch.
- Q_IN, input, 1: latch Q. Asynchronous to CLK.
- Q_SYNC, output, 1: Q_IN after the two-flop synchronizer (second flop).
- DONE, output, 1: one-cycle pulse when a request completes with a readback match.
- ERR, output, 1: one-cycle pulse when readback times out.

## Operation
- States: INIT_PULSE, INIT_GAP, INIT_CHECK, IDLE, PULSE, GAP, CHECK.
- All outputs are registered. Internal registers: a cycle counter wide enough for max(PULSE_W, GAP_W, TIMEOUT), and a target-value register.
- While RST_L is low:
  - state = INIT_PULSE, counter = 0.
  - S = R = REQ_READY = DONE = ERR = 0.
  - Both synchronizer flops = 0.
- INIT sequence (forces the latch to a known state):
  - INIT_PULSE: R = 1 for PULSE_W cycles.
  - INIT_GAP: GAP_W cycles with S = R = 0.
  - INIT_CHECK: target = 0, same rules as CHECK.
  - On a match, go to IDLE without a DONE pulse.
  - On a timeout, pulse ERR and go to IDLE.
- IDLE:
  - REQ_READY = 1, S = R = 0.
  - A handshake occurs when REQ_VALID and REQ_READY are both 1 at a rising edge.
  - On a handshake: target ← REQ_VAL, go to PULSE, REQ_READY drops.
- PULSE: S = target and R = ~target for exactly PULSE_W cycles, then go to GAP.
- GAP: S = R = 0 for exactly GAP_W cycles, then go to CHECK.
- CHECK:
  - Compare Q_SYNC with target each cycle, for up to TIMEOUT cycles.
  - On the first match: next cycle is IDLE with DONE = 1.
  - If no match after TIMEOUT cycles: next cycle is IDLE with ERR = 1.
- Every request always issues a pulse, even when the latch already holds the target value.
- Invariants:
  - S & R is never 1.
  - S or R is high only in PULSE or INIT_PULSE.
  - DONE & ERR is never 1.
  - REQ_VAL and REQ_VALID are ignored outside IDLE.

## Timing
- Cycle numbering: cycle 0 is the cycle whose closing edge performs the handshake.
- Pulse: S or R is high in cycles 1..PULSE_W.
- Gap: S = R = 0 in cycles PULSE_W+1..PULSE_W+GAP_W.
- CHECK starts in cycle PULSE_W+GAP_W+1.
- Minimum latency: DONE and REQ_READY are high in cycle PULSE_W+GAP_W+2, i.e. cycle 7 at the defaults.
- Back-to-back requests: the earliest next handshake is in the DONE/ERR cycle itself.
- Q_SYNC lags Q_IN by 2 edges.
- Worst-case ERR: cycle PULSE_W+GAP_W+TIMEOUT+1.
- INIT after reset release (counting from the first edge with RST_L sampled high):
  - R is high for cycles 1..PULSE_W.
  - REQ_READY rises in cycle PULSE_W+GAP_W+2 or later.
- Reset mid-operation: at the next edge, S and R drop to 0, any pending DONE/ERR is discarded, and the INIT sequence restarts.

## Test plan
- Reset then release, bench latch model (20 ns NOR loop, 10 ns CLK) starting with Q = 1 → R high cycles 1–3, S never high, REQ_READY = 1 from cycle 7, no DONE, no ERR.
- Request REQ_VAL = 1 from IDLE → S high cycles 1–3, R = 0 throughout, DONE = 1 and REQ_READY = 1 in cycle 7, Q_SYNC = 1.
- Back-to-back requests 1 then 0, with the second handshake in the DONE cycle → second R pulse starts the next cycle, second DONE 7 cycles after the second handshake, S and R never overlap.
- Latch model stuck at 0, request REQ_VAL = 1 → ERR = 1 in cycle 22 (3 + 2 + 16 + 1), DONE never asserts, REQ_READY returns to 1.
- RST_L driven low in cycle 2 of a set pulse → S = 0 at the next edge, no DONE, and the INIT R pulse follows after release.
- REQ_VALID held high with REQ_VAL toggling every cycle during PULSE/GAP/CHECK → only the value captured at the handshake is driven, and exactly one DONE per handshake.
